// File: rtl/seq_divider.sv
// Restoring shift-and-subtract divider: one quotient bit per clock, start/busy/done handshake.
// Define SEQ_DIV_SIGNED_EN for two's-complement operands and results (sign fix-up in the done cycle).
module seq_divider #(
    parameter int DIVIDEND_W = 16,
    parameter int DIVISOR_W  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic                  busy,
    output logic                  done,
    output logic [DIVIDEND_W-1:0] quotient,
    output logic [DIVISOR_W-1:0]  remainder,
    output logic                  div_by_zero
);
    localparam int CNT_W = (DIVIDEND_W > 1) ? $clog2(DIVIDEND_W) : 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [DIVISOR_W:0]    rem_q, rem_d;
    logic [DIVIDEND_W-1:0] work_q, work_d;
    logic [DIVISOR_W-1:0]  dvsr_q, dvsr_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic [DIVIDEND_W-1:0] quotient_q, quotient_d;
    logic [DIVISOR_W-1:0]  remainder_q, remainder_d;
    logic                  dbz_q, dbz_d;

    logic [DIVISOR_W:0]    shifted;
    logic                  fits;
    logic [DIVISOR_W:0]    new_rem;
    logic [DIVIDEND_W-1:0] new_work;
    logic [DIVIDEND_W-1:0] dd_mag, q_fin;
    logic [DIVISOR_W-1:0]  ds_mag, r_fin;
    logic                  unused_rem_msb;

    // The partial remainder is always below the divisor before the shift, so its MSB is never needed as input.
    assign shifted        = {rem_q[DIVISOR_W-1:0], work_q[DIVIDEND_W-1]};
    assign fits           = (shifted >= {1'b0, dvsr_q});
    assign new_rem        = fits ? (shifted - {1'b0, dvsr_q}) : shifted;
    assign new_work       = {work_q[DIVIDEND_W-2:0], fits};
    assign unused_rem_msb = rem_q[DIVISOR_W];

`ifdef SEQ_DIV_SIGNED_EN
    logic qneg_q, qneg_d;
    logic rneg_q, rneg_d;

    // Magnitudes are taken as unsigned, so the most-negative value maps onto itself correctly.
    assign dd_mag = dividend[DIVIDEND_W-1] ? (~dividend + DIVIDEND_W'(1)) : dividend;
    assign ds_mag = divisor[DIVISOR_W-1]   ? (~divisor + DIVISOR_W'(1))   : divisor;
    assign q_fin  = qneg_q ? (~new_work + DIVIDEND_W'(1)) : new_work;
    assign r_fin  = rneg_q ? (~new_rem[DIVISOR_W-1:0] + DIVISOR_W'(1)) : new_rem[DIVISOR_W-1:0];

    always_comb begin
        qneg_d = qneg_q;
        rneg_d = rneg_q;
        if (state_q != S_RUN && start) begin
            qneg_d = dividend[DIVIDEND_W-1] ^ divisor[DIVISOR_W-1];
            rneg_d = dividend[DIVIDEND_W-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            qneg_q <= 1'b0;
            rneg_q <= 1'b0;
        end else begin
            qneg_q <= qneg_d;
            rneg_q <= rneg_d;
        end
    end
`else
    assign dd_mag = dividend;
    assign ds_mag = divisor;
    assign q_fin  = new_work;
    assign r_fin  = new_rem[DIVISOR_W-1:0];
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rem_d       = rem_q;
        work_d      = work_q;
        dvsr_d      = dvsr_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;
        case (state_q)
            S_RUN: begin
                rem_d  = new_rem;
                work_d = new_work;
                cnt_d  = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(DIVIDEND_W - 1)) begin
                    state_d     = S_DONE;
                    busy_d      = 1'b0;
                    done_d      = 1'b1;
                    quotient_d  = q_fin;
                    remainder_d = r_fin;
                    dbz_d       = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                if (start) begin
                    dvsr_d = ds_mag;
                    if (divisor == '0) begin
                        state_d     = S_DONE;
                        done_d      = 1'b1;
                        quotient_d  = '1;
                        remainder_d = '0;
                        dbz_d       = 1'b1;
                    end else begin
                        state_d = S_RUN;
                        busy_d  = 1'b1;
                        rem_d   = '0;
                        work_d  = dd_mag;
                        cnt_d   = '0;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            rem_q       <= '0;
            work_q      <= '0;
            dvsr_q      <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rem_q       <= rem_d;
            work_q      <= work_d;
            dvsr_q      <= dvsr_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;
endmodule

// File: tb/tb_seq_divider.sv
// Randomised scoreboard bench for seq_divider: driver pushes expected results, monitor pops on done.
module tb_seq_divider;
    localparam int DW = 16;
    localparam int VW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [DW-1:0] dividend = '0;
    logic [VW-1:0] divisor = '0;
    logic          busy, done, div_by_zero;
    logic [DW-1:0] quotient;
    logic [VW-1:0] remainder;

    seq_divider #(.DIVIDEND_W(DW), .DIVISOR_W(VW)) dut (
        .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
        .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] a;
        logic [VW-1:0] b;
        logic [DW-1:0] q;
        logic [VW-1:0] r;
        logic          z;
        int            acc;
        int            lat;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference: plain integer division; SV '/' and '%' truncate toward zero with remainder sign of dividend.
    function automatic exp_t model(input logic [DW-1:0] a, input logic [VW-1:0] b, input int acc);
        exp_t e;
        e.a = a; e.b = b; e.acc = acc;
        if (b == '0) begin
            e.q = '1; e.r = '0; e.z = 1'b1; e.lat = 1;
        end else begin
            e.z = 1'b0; e.lat = DW + 1;
`ifdef SEQ_DIV_SIGNED_EN
            begin
                int sa, sbv;
                sa  = int'($signed(a));
                sbv = int'($signed(b));
                e.q = DW'(sa / sbv);
                e.r = VW'(sa % sbv);
            end
`else
            e.q = a / DW'(b);
            e.r = VW'(a % DW'(b));
`endif
        end
        return e;
    endfunction

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (!rst && done === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 required no pending result (cycle %0d)", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                $display("txn %04h / %02h -> q=%04h r=%02h z=%b lat=%0d", e.a, e.b, quotient, remainder,
                         div_by_zero, cyc - e.acc);
                check("quotient", 32'(quotient), 32'(e.q));
                check("remainder", 32'(remainder), 32'(e.r));
                check("div_by_zero", 32'(div_by_zero), 32'(e.z));
                check("latency", 32'(cyc - e.acc), 32'(e.lat));
                check("busy_at_done", 32'(busy), 32'd0);
            end
        end
    end

    task automatic issue(input logic [DW-1:0] a, input logic [VW-1:0] b, input bit hold);
        int n = 0;
        @(negedge clk); #1;
        while (busy !== 1'b0 && n < 100) begin
            @(negedge clk); #1;
            n++;
        end
        if (n >= 100) begin
            checks++;
            errors++;
            $display("FAIL busy_timeout: got busy=%b required 0 within 100 cycles", busy);
        end
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        sb.push_back(model(a, b, cyc));
        @(posedge clk); #1;
        if (!hold) start = 1'b0;
        dividend = DW'($urandom);
        divisor  = VW'($urandom);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_quotient"}, 32'(quotient), 32'd0);
        check({tag, "_remainder"}, 32'(remainder), 32'd0);
        check({tag, "_dbz"}, 32'(div_by_zero), 32'd0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 1'b0;

        issue(16'd1000, 8'd7, 1'b0);
        issue(16'hFFFF, 8'hFF, 1'b0);
        issue(16'd3, 8'd200, 1'b0);
        issue(16'd5, 8'd0, 1'b0);
        issue(16'd10, 8'd2, 1'b0);
        issue(16'hFC18, 8'd7, 1'b0);
        issue(16'h8000, 8'hFF, 1'b0);

        // A start pulse mid-run with different operands must not disturb 1000 / 7.
        issue(16'd1000, 8'd7, 1'b0);
        repeat (3) @(negedge clk);
        #1;
        start = 1'b1; dividend = 16'd99; divisor = 8'd3;
        @(negedge clk); #1;
        start = 1'b0;

        // Start held high: back-to-back results, operands scrambled while running.
        issue(16'd1000, 8'd7, 1'b1);
        issue(16'd5, 8'd0, 1'b1);
        issue(16'd40000, 8'd13, 1'b1);
        issue(16'd77, 8'd9, 1'b0);

        // Reset mid-run: no done pulse, outputs cleared, next operation normal.
        issue(16'd1000, 8'd7, 1'b0);
        repeat (6) @(negedge clk);
        #1;
        rst = 1'b1;
        sb.delete();
        @(negedge clk); #1;
        rst = 1'b0;
        check_reset_outputs("abort");
        repeat (20) @(negedge clk);
        issue(16'd10, 8'd2, 1'b0);

        for (int i = 0; i < 30; i++) begin
            logic [VW-1:0] b;
            b = ($urandom_range(0, 7) == 0) ? '0 : VW'($urandom);
            issue(DW'($urandom), b, bit'($urandom_range(0, 1)));
        end

        begin
            int n = 0;
            @(negedge clk); #1;
            start = 1'b0;
            while (sb.size() != 0 && n < 200) begin
                @(negedge clk);
                n++;
            end
            if (sb.size() != 0) begin
                checks++;
                errors++;
                $display("FAIL drain_timeout: got %0d pending results required 0", sb.size());
            end
        end
        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
